// File: rtl/bus_master_port.sv
// Serial-bus master port: takes a parallel read/write request, wins the bus,
// shifts address/write data out LSB-first and deserialises read responses.
module bus_master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dreq,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic                  dready,
    output logic                  dvalid,
    output logic                  derr,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  mbreq,
    input  logic                  mbgrant,
    output logic                  mwdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  mrdata,
    input  logic                  svalid,
    input  logic                  sready,
    input  logic                  ssplit
);

    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int BC_W  = $clog2(MAX_W) + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int AI_W  = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam int DI_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
    localparam logic [BC_W-1:0] ADDR_LAST = BC_W'(ADDR_WIDTH - 1);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_WIDTH - 1);
    localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, REQ, ADDR, WDATA, RWAIT, SPLIT, RDATA, DONE
    } state_t;

    state_t                  state_q, state_n;
    logic [BC_W-1:0]         bitcnt_q, bitcnt_n;
    logic [TO_W-1:0]         tocnt_q, tocnt_n;
    logic                    split_q, split_n;

    logic                    mode_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdbuf_q;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic                    accept;
    logic                    capture;
    logic                    load_word;
    logic                    timed_out;

    logic                    mbreq_n, mvalid_n, mwdata_n, mmode_n, dvalid_n, derr_n;

    assign dready = (state_q == IDLE);

    // Read buffer with the bit arriving this cycle merged in at its position.
    always_comb begin
        rd_word = rdbuf_q;
        rd_word[bitcnt_q[DI_W-1:0]] = mrdata;
    end

    always_comb begin
        state_n   = state_q;
        bitcnt_n  = bitcnt_q;
        tocnt_n   = tocnt_q;
        split_n   = split_q;
        accept    = 1'b0;
        capture   = 1'b0;
        load_word = 1'b0;
        timed_out = 1'b0;

        case (state_q)
            IDLE: begin
                if (dreq) begin
                    accept   = 1'b1;
                    state_n  = REQ;
                    bitcnt_n = '0;
                    tocnt_n  = '0;
                    split_n  = 1'b0;
                end
            end
            REQ: begin
                if (mbgrant && sready) begin
                    state_n  = ADDR;
                    bitcnt_n = '0;
                end
            end
            ADDR: begin
                if (bitcnt_q == ADDR_LAST) begin
                    bitcnt_n = '0;
                    state_n  = mode_q ? WDATA : RWAIT;
                end else begin
                    bitcnt_n = bitcnt_q + BC_ONE;
                end
            end
            WDATA: begin
                if (bitcnt_q == DATA_LAST) begin
                    bitcnt_n = '0;
                    state_n  = DONE;
                end else begin
                    bitcnt_n = bitcnt_q + BC_ONE;
                end
            end
            RWAIT, SPLIT: begin
                if (svalid) begin
                    capture  = 1'b1;
                    bitcnt_n = BC_ONE;
                    state_n  = RDATA;
                end else if ((state_q == RWAIT) && ssplit) begin
                    state_n = SPLIT;
                    split_n = 1'b1;
                end else begin
                    // Saturating wait counter shared by RWAIT and SPLIT.
                    tocnt_n = (tocnt_q == TO_MAX) ? tocnt_q : tocnt_q + TO_ONE;
                    if (tocnt_n == TO_MAX) begin
                        timed_out = 1'b1;
                        state_n   = DONE;
                    end
                end
            end
            RDATA: begin
                if (svalid) begin
                    capture = 1'b1;
                    if (bitcnt_q == DATA_LAST) begin
                        load_word = 1'b1;
                        bitcnt_n  = '0;
                        state_n   = DONE;
                    end else begin
                        bitcnt_n = bitcnt_q + BC_ONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        mvalid_n = (state_n == ADDR) || (state_n == WDATA);
        mmode_n  = mode_q && mvalid_n;
        mwdata_n = 1'b0;
        if (state_n == ADDR) begin
            mwdata_n = addr_q[bitcnt_n[AI_W-1:0]];
        end else if (state_n == WDATA) begin
            mwdata_n = wdata_q[bitcnt_n[DI_W-1:0]];
        end
        mbreq_n  = (state_n == REQ) || (state_n == ADDR) || (state_n == WDATA) ||
                   (state_n == RWAIT) || ((state_n == RDATA) && !split_n);
        dvalid_n = (state_n == DONE);
        derr_n   = timed_out;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            tocnt_q  <= '0;
            split_q  <= 1'b0;
            mbreq    <= 1'b0;
            mvalid   <= 1'b0;
            mwdata   <= 1'b0;
            mmode    <= 1'b0;
            dvalid   <= 1'b0;
            derr     <= 1'b0;
            drdata   <= '0;
        end else begin
            state_q  <= state_n;
            bitcnt_q <= bitcnt_n;
            tocnt_q  <= tocnt_n;
            split_q  <= split_n;
            mbreq    <= mbreq_n;
            mvalid   <= mvalid_n;
            mwdata   <= mwdata_n;
            mmode    <= mmode_n;
            dvalid   <= dvalid_n;
            derr     <= derr_n;
            if (load_word) begin
                drdata <= rd_word;
            end
        end
    end

    // Request payload and read shift buffer carry no reset; they are only
    // consumed after being written by an accepted transaction.
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_q  <= dmode;
            addr_q  <= daddr;
            wdata_q <= dwdata;
        end
        if (capture) begin
            rdbuf_q <= rd_word;
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: table of directed transactions plus randomized
// ones, each checked cycle by cycle against a transaction-level slave model.
module tb_bus_master_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 255;
    localparam int L  = 600;

    logic          clk = 1'b0;
    logic          rstn;
    logic          dreq, dmode;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic          dready, dvalid, derr;
    logic [DW-1:0] drdata;
    logic          mbreq, mbgrant, mwdata, mmode, mvalid;
    logic          mrdata, svalid, sready, ssplit;

    int checks = 0;
    int fails  = 0;

    bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .dreq(dreq), .dmode(dmode), .daddr(daddr),
        .dwdata(dwdata), .dready(dready), .dvalid(dvalid), .derr(derr),
        .drdata(drdata), .mbreq(mbreq), .mbgrant(mbgrant), .mwdata(mwdata),
        .mmode(mmode), .mvalid(mvalid), .mrdata(mrdata), .svalid(svalid),
        .sready(sready), .ssplit(ssplit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gd;
        int            sd;
        int            gap;
        int            split_at;
        bit            silent;
        bit            holes;
        logic [DW-1:0] rdata;
        bit            exp_err;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t          vecs[7];
    logic [DW-1:0] model_rd;
    bit            sv[L];
    bit            rd[L];
    bit            sp[L];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic noise();
        svalid = 1'($urandom);
        mrdata = 1'($urandom);
        ssplit = 1'($urandom);
    endtask

    task automatic run_txn(input vec_t v);
        logic [AW+DW-1:0] stream;
        logic             both;
        int n, c, got, w, bi, d, wcap, splitc, nb, cnt, insplit, err;
        stream = {v.wdata, v.addr};
        n = v.mode ? AW + DW : AW;

        chk("idle_dready", dready, 1);
        dreq = 1'b1; dmode = v.mode; daddr = v.addr; dwdata = v.wdata;
        mbgrant = 1'b0; sready = 1'b0;
        noise();
        @(negedge clk);
        dreq = 1'b0; dmode = 1'($urandom); daddr = AW'($urandom); dwdata = DW'($urandom);
        chk("req_mbreq", mbreq, 1);
        chk("req_dready", dready, 0);

        c = 0; got = 0;
        while (got == 0 && c < 200) begin
            mbgrant = (c >= v.gd);
            sready  = (c >= v.sd);
            both    = mbgrant && sready;
            noise();
            @(negedge clk);
            if (both) got = 1;
            else begin
                chk("req_mvalid", mvalid, 0);
                chk("req_hold_mbreq", mbreq, 1);
            end
            c++;
        end
        chk("grant_reached", got, 1);

        for (int i = 0; i < n; i++) begin
            chk("ser_mvalid", mvalid, 1);
            chk("ser_bit", mwdata, stream[i]);
            chk("ser_mmode", mmode, v.mode);
            noise();
            @(negedge clk);
        end
        chk("post_mvalid", mvalid, 0);

        if (v.mode) begin
            chk("wr_dvalid", dvalid, 1);
            chk("wr_derr", derr, v.exp_err);
            chk("wr_mbreq", mbreq, 0);
            chk("wr_drdata", drdata, v.exp_rd);
        end else begin
            // Slave response schedule: idle gap, optional split, data bits with holes.
            for (int k = 0; k < L; k++) begin
                sv[k] = 1'b0; rd[k] = 1'($urandom); sp[k] = 1'b0;
            end
            if (!v.silent) begin
                w = v.gap;
                for (int b = 0; b < DW; b++) begin
                    if (v.holes && b > 0) begin
                        bi = $urandom_range(0, 2);
                        for (int h = 0; h < bi; h++) begin
                            sp[w] = 1'($urandom);
                            w++;
                        end
                    end
                    sv[w] = 1'b1; rd[w] = v.rdata[b]; w++;
                end
            end
            if (v.split_at >= 0) sp[v.split_at] = 1'b1;

            // Expected completion cycle from the transaction rules.
            d = -1; wcap = -1; splitc = -1; nb = 0; cnt = 0; insplit = 0; err = 0;
            for (int k = 0; k < L && d < 0; k++) begin
                if (nb == 0) begin
                    if (sv[k]) begin
                        nb = 1; wcap = k;
                    end else if (sp[k] && insplit == 0) begin
                        insplit = 1; splitc = k;
                    end else begin
                        cnt++;
                        if (cnt >= TO) begin d = k + 1; err = 1; end
                    end
                end else if (sv[k]) begin
                    nb++;
                    if (nb == DW) d = k + 1;
                end
            end
            if (d < 0) d = L;

            w = 0;
            while (w < d && w < L) begin
                chk("rd_dvalid_low", dvalid, 0);
                if (wcap < 0 || w <= wcap)
                    chk("rd_wait_mbreq", mbreq, (splitc >= 0 && splitc < w) ? 0 : 1);
                svalid = sv[w]; mrdata = rd[w]; ssplit = sp[w];
                @(negedge clk);
                w++;
            end
            chk("rd_dvalid", dvalid, 1);
            chk("rd_derr", derr, v.exp_err);
            chk("rd_derr_model", derr, err);
            chk("rd_drdata", drdata, v.exp_rd);
            chk("rd_done_mbreq", mbreq, 0);
        end

        noise();
        mbgrant = 1'b0;
        @(negedge clk);
        chk("after_dvalid", dvalid, 0);
        chk("after_dready", dready, 1);
        model_rd = v.exp_rd;
    endtask

    initial begin
        vecs[0] = '{1'b1, 12'h3C7, 8'hA5, 0, 0, 0, -1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 12'h0FF, 8'h00, 0, 0, 3, -1, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h5A};
        vecs[2] = '{1'b0, 12'h123, 8'h00, 0, 0, 5,  1, 1'b0, 1'b0, 8'hC3, 1'b0, 8'hC3};
        vecs[3] = '{1'b0, 12'h456, 8'h00, 0, 0, 0, -1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hC3};
        vecs[4] = '{1'b1, 12'h800, 8'h01, 5, 2, 0, -1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hC3};
        vecs[5] = '{1'b0, 12'h001, 8'h00, 1, 5, 0, -1, 1'b0, 1'b1, 8'h81, 1'b0, 8'h81};
        vecs[6] = '{1'b0, 12'hABC, 8'h00, 0, 0, 4,  2, 1'b1, 1'b0, 8'h00, 1'b1, 8'h81};

        rstn = 1'b1; dreq = 1'b0; dmode = 1'b0; daddr = '0; dwdata = '0;
        mbgrant = 1'b0; mrdata = 1'b0; svalid = 1'b0; sready = 1'b0; ssplit = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_mbreq", mbreq, 0);
        chk("rst_mvalid", mvalid, 0);
        chk("rst_mwdata", mwdata, 0);
        chk("rst_mmode", mmode, 0);
        chk("rst_dvalid", dvalid, 0);
        chk("rst_derr", derr, 0);
        chk("rst_drdata", drdata, 0);
        chk("rst_dready", dready, 1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        model_rd = '0;

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Reset in the middle of the address phase of a write.
        chk("mid_dready", dready, 1);
        dreq = 1'b1; dmode = 1'b1; daddr = 12'h155; dwdata = 8'h3C;
        mbgrant = 1'b1; sready = 1'b1;
        @(negedge clk);
        dreq = 1'b0;
        @(negedge clk);
        chk("mid_mvalid", mvalid, 1);
        chk("mid_mmode", mmode, 1);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_mvalid", mvalid, 0);
        chk("arst_mbreq", mbreq, 0);
        chk("arst_mmode", mmode, 0);
        chk("arst_mwdata", mwdata, 0);
        chk("arst_dvalid", dvalid, 0);
        chk("arst_drdata", drdata, 0);
        chk("arst_dready", dready, 1);
        mbgrant = 1'b0; sready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_dvalid", dvalid, 0);
        model_rd = '0;
        begin
            vec_t v;
            v = '{1'b1, 12'h2D4, 8'h96, 1, 0, 0, -1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
            run_txn(v);
        end

        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v.mode   = 1'($urandom);
            v.addr   = AW'($urandom);
            v.wdata  = DW'($urandom);
            v.gd     = $urandom_range(0, 3);
            v.sd     = $urandom_range(0, 3);
            v.gap    = $urandom_range(0, 5);
            v.split_at = (v.gap > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, v.gap - 1) : -1;
            v.silent = ($urandom_range(0, 7) == 0);
            v.holes  = 1'b1;
            v.rdata  = DW'($urandom);
            v.exp_err = !v.mode && v.silent;
            v.exp_rd  = (v.mode || v.silent) ? model_rd : v.rdata;
            run_txn(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
